// File: rtl/add_sub_issue.sv
// rtl/add_sub_issue.sv - sequencing stage around an external ripple-carry adder
// Accepts add/sub requests, waits SETTLE_CYCLES for the adder, registers sum and ALU flags.
module add_sub_issue #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_A,
  input  logic [WIDTH-1:0] io_in_B,
  input  logic             io_in_op,
  output logic [WIDTH-1:0] io_add_A,
  output logic [WIDTH-1:0] io_add_B,
  output logic             io_add_Cin,
  input  logic [WIDTH-1:0] io_add_Sum,
  input  logic             io_add_Cout,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_result,
  output logic             io_out_carry,
  output logic             io_out_overflow,
  output logic             io_out_zero,
  output logic             io_out_neg
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, bx;
  logic             op_q;
  logic [CW-1:0]    cnt;
  logic             in_fire, out_fire, settle_done;

  assign bx          = op_q ? ~b_q : b_q;
  assign io_add_A    = a_q;
  assign io_add_B    = bx;
  assign io_add_Cin  = op_q;
  assign in_fire     = io_in_valid & io_in_ready;
  assign out_fire    = io_out_valid & io_out_ready;
  assign settle_done = (state == CALC) && (cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_fire) state_nx = CALC;
      CALC:    if (settle_done) state_nx = DONE;
      DONE:    if (out_fire) state_nx = in_fire ? CALC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // in_ready is gated by reset so no request can be taken while reset is held low
  always_comb begin
    io_in_ready  = 1'b0;
    io_out_valid = 1'b0;
    case (state)
      IDLE:    io_in_ready = reset;
      DONE: begin
        io_out_valid = 1'b1;
        io_in_ready  = reset & io_out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q             <= '0;
      b_q             <= '0;
      op_q            <= 1'b0;
      cnt             <= '0;
      io_out_result   <= '0;
      io_out_carry    <= 1'b0;
      io_out_overflow <= 1'b0;
      io_out_zero     <= 1'b0;
      io_out_neg      <= 1'b0;
    end else begin
      if (in_fire) begin
        a_q  <= io_in_A;
        b_q  <= io_in_B;
        op_q <= io_in_op;
        cnt  <= '0;
      end else if (state == CALC) begin
        cnt <= cnt + CW'(1);
      end
      if (settle_done) begin
        io_out_result   <= io_add_Sum;
        io_out_carry    <= op_q ? ~io_add_Cout : io_add_Cout;
        io_out_overflow <= (a_q[WIDTH-1] == bx[WIDTH-1]) && (io_add_Sum[WIDTH-1] != a_q[WIDTH-1]);
        io_out_zero     <= (io_add_Sum == '0);
        io_out_neg      <= io_add_Sum[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_add_sub_issue.sv
// tb/tb_add_sub_issue.sv - directed scoreboard bench for add_sub_issue
// Two instances: SETTLE_CYCLES=1 for most steps, SETTLE_CYCLES=3 for the latency step.
module tb_add_sub_issue;

  typedef struct packed {
    logic [7:0] res;
    logic       c, v, z, n;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, in_valid, out_ready, in_op, in_valid3;
  logic [7:0] in_a, in_b;

  logic       in_ready, add_cin, out_valid, carry, ovf, zero, neg, add_cout;
  logic [7:0] add_a, add_b, add_sum, result;
  logic       in_ready3, add_cin3, out_valid3, carry3, ovf3, zero3, neg3, add_cout3;
  logic [7:0] add_a3, add_b3, add_sum3, result3;

  assign {add_cout, add_sum}   = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  assign {add_cout3, add_sum3} = {1'b0, add_a3} + {1'b0, add_b3} + {8'd0, add_cin3};

  add_sub_issue #(.WIDTH(8), .SETTLE_CYCLES(1)) dut (
    .clock(clock), .reset(reset), .io_in_valid(in_valid), .io_in_ready(in_ready),
    .io_in_A(in_a), .io_in_B(in_b), .io_in_op(in_op),
    .io_add_A(add_a), .io_add_B(add_b), .io_add_Cin(add_cin),
    .io_add_Sum(add_sum), .io_add_Cout(add_cout),
    .io_out_valid(out_valid), .io_out_ready(out_ready), .io_out_result(result),
    .io_out_carry(carry), .io_out_overflow(ovf), .io_out_zero(zero), .io_out_neg(neg)
  );

  add_sub_issue #(.WIDTH(8), .SETTLE_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset), .io_in_valid(in_valid3), .io_in_ready(in_ready3),
    .io_in_A(in_a), .io_in_B(in_b), .io_in_op(in_op),
    .io_add_A(add_a3), .io_add_B(add_b3), .io_add_Cin(add_cin3),
    .io_add_Sum(add_sum3), .io_add_Cout(add_cout3),
    .io_out_valid(out_valid3), .io_out_ready(1'b1), .io_out_result(result3),
    .io_out_carry(carry3), .io_out_overflow(ovf3), .io_out_zero(zero3), .io_out_neg(neg3)
  );

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic op);
    exp_t e;
    logic [8:0] wide;
    wide = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    e.res = wide[7:0];
    e.c   = op ? (a < b) : wide[8];
    e.v   = op ? ((a[7] != b[7]) && (e.res[7] != a[7])) : ((a[7] == b[7]) && (e.res[7] != a[7]));
    e.z   = (e.res == 8'h00);
    e.n   = e.res[7];
    return e;
  endfunction

  // Drive a request at a negedge, accept on the next posedge, return at the following negedge
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic op);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    chk("accept_ready", in_ready, 1);
    q.push_back(model(a, b, op));
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_edges);
    int n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clock);
      @(negedge clock);
      n++;
    end
    chk(tag, n, exp_edges);
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = q.pop_front();
      chk({tag, "_result"}, {24'd0, result}, {24'd0, e.res});
      chk({tag, "_flags"}, {carry, ovf, zero, neg}, {e.c, e.v, e.z, e.n});
    end
  endtask

  task automatic consume;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_valid3 = 1'b0; out_ready = 1'b1;
    in_a = 8'h00; in_b = 8'h00; in_op = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", {result, carry, ovf, zero, neg}, 0);
    chk("rst_adder_drive", {add_a, add_b, add_cin}, 0);
    reset = 1'b1;
    #1 chk("rel_in_ready", in_ready, 1);
    @(negedge clock);

    send(8'h25, 8'h13, 1'b0);
    chk("t1_valid_low_in_calc", out_valid, 0);
    wait_valid("t1_latency", 2);
    compare_result("t1");
    consume();

    send(8'h10, 8'h20, 1'b1);
    chk("t2_adder_b", add_b, 8'hDF);
    chk("t2_adder_cin", add_cin, 1);
    wait_valid("t2_latency", 2);
    compare_result("t2");
    consume();

    send(8'h7F, 8'h01, 1'b0);
    wait_valid("t3a_latency", 2);
    compare_result("t3a");
    consume();
    send(8'hFF, 8'h01, 1'b0);
    wait_valid("t3b_latency", 2);
    compare_result("t3b");
    consume();

    send(8'h80, 8'h01, 1'b1);
    wait_valid("t4_latency", 2);
    compare_result("t4");
    consume();

    // Backpressure in DONE, then simultaneous out/in handshakes
    out_ready = 1'b0;
    send(8'h40, 8'h40, 1'b0);
    wait_valid("t5_latency", 2);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_result", result, q[0].res);
      chk("t5_hold_in_ready", in_ready, 0);
      chk("t5_hold_valid", out_valid, 1);
      @(negedge clock);
    end
    out_ready = 1'b1;
    in_a = 8'h01; in_b = 8'h01; in_op = 1'b0; in_valid = 1'b1;
    #1 chk("t5_in_ready_follows_out_ready", in_ready, 1);
    compare_result("t5_held");
    q.push_back(model(8'h01, 8'h01, 1'b0));
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    chk("t5_valid_dropped", out_valid, 0);
    chk("t5_calc_in_ready", in_ready, 0);
    wait_valid("t5b_latency", 2);
    compare_result("t5b");
    consume();

    // Reset during CALC discards the op
    in_a = 8'h11; in_b = 8'h22; in_op = 1'b0; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b0;
    #1 chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_result", result, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1 chk("t6_rel_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t6_no_stale", out_valid, 0);
    end

    // Reset during DONE also drops the result
    send(8'h05, 8'h03, 1'b1);
    wait_valid("t6b_latency", 2);
    reset = 1'b0;
    void'(q.pop_front());
    #1 chk("t6b_rst_valid", out_valid, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("t6b_no_stale", out_valid, 0);

    // SETTLE_CYCLES=3 instance: latency of 4 edges
    begin
      int n = 1;
      exp_t e;
      in_a = 8'h25; in_b = 8'h13; in_op = 1'b0; in_valid3 = 1'b1;
      chk("t7_accept_ready", in_ready3, 1);
      e = model(8'h25, 8'h13, 1'b0);
      @(posedge clock);
      @(negedge clock);
      in_valid3 = 1'b0;
      while (!out_valid3 && n < 20) begin
        @(posedge clock);
        @(negedge clock);
        n++;
      end
      chk("t7_latency", n, 4);
      chk("t7_result", result3, e.res);
      chk("t7_flags", {carry3, ovf3, zero3, neg3}, {e.c, e.v, e.z, e.n});
      chk("t7_dut1_ignored", out_valid, 0);
    end

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
